// File: rtl/switch_mcu_fetch_pc_if.sv
// Fetch-stage bus bundle: redirect from EX, instruction memory port, decoder handshake.
// master = fetch unit, slave = surrounding pipeline/memory.
interface switch_mcu_fetch_pc_if;
    logic        in_pc_override;
    logic [31:0] in_pc_write;
    logic [1:0]  in_flush;
    logic        out_imem_ren;
    logic [31:0] out_imem_addr;
    logic [31:0] in_imem_rdata;
    logic [31:0] out_instr;
    logic [31:0] out_instr_pc;
    logic        out_instr_valid;
    logic        in_dec_ready;
    logic [31:0] out_pc_reg;

    modport master (
        input  in_pc_override, in_pc_write, in_flush, in_imem_rdata, in_dec_ready,
        output out_imem_ren, out_imem_addr, out_instr, out_instr_pc, out_instr_valid, out_pc_reg
    );

    modport slave (
        output in_pc_override, in_pc_write, in_flush, in_imem_rdata, in_dec_ready,
        input  out_imem_ren, out_imem_addr, out_instr, out_instr_pc, out_instr_valid, out_pc_reg
    );
endinterface

// File: rtl/switch_mcu_fetch_pc.sv
// PC register and fetch sequencer with a two-entry instruction buffer.
// state    | meaning
// S_IDLE   | one settling cycle after reset release, no fetch
// S_RUN    | issue fetches while buffer plus in-flight stays below depth
// S_BUBBLE | post-redirect dead cycles, counter counts down to 0
module switch_mcu_fetch_pc #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                  in_clk,
    input  logic                  in_rst,
    switch_mcu_fetch_pc_if.master bus
);
    localparam logic [1:0] DEPTH = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BUBBLE} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state;
    logic [1:0]  bub_cnt;
    logic        ovr_q;
    logic [31:0] pc;
    logic        ren_q;
    logic [31:0] addr_q;
    entry_t      ent0;
    entry_t      ent1;
    logic [1:0]  occ;

    logic        redir;
    logic [1:0]  flush_eff;
    logic        pop;
    logic [1:0]  occ_pop;
    logic [1:0]  fill;
    logic        issue;
    entry_t      nxt0;
    entry_t      nxt1;

    always_comb begin
        redir     = bus.in_pc_override && !ovr_q;
        flush_eff = (bus.in_flush == 2'd3) ? 2'd2 : bus.in_flush;
        pop       = (occ != 2'd0) && bus.in_dec_ready;
        occ_pop   = occ - {1'b0, pop};
        // ren_q is the single in-flight fetch; its word lands this cycle
        fill      = occ_pop + {1'b0, ren_q};
        issue     = (state == S_RUN) && !redir && (fill < DEPTH);
        nxt0      = pop ? ent1 : ent0;
        nxt1      = ent1;
        if (ren_q) begin
            if (occ_pop == 2'd0) begin
                nxt0 = {addr_q, bus.in_imem_rdata};
            end else begin
                nxt1 = {addr_q, bus.in_imem_rdata};
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state   <= S_IDLE;
            bub_cnt <= 2'd0;
            ovr_q   <= 1'b0;
            pc      <= RESET_PC;
            ren_q   <= 1'b0;
            addr_q  <= 32'h0;
            ent0    <= '0;
            ent1    <= '0;
            occ     <= 2'd0;
        end else begin
            ovr_q <= bus.in_pc_override;
            ren_q <= issue;
            if (issue) begin
                addr_q <= pc;
                pc     <= pc + 32'd4;
            end
            // redirect drops the buffer and the word returning this cycle
            if (redir) begin
                pc  <= bus.in_pc_write;
                occ <= 2'd0;
            end else begin
                ent0 <= nxt0;
                ent1 <= nxt1;
                occ  <= fill;
            end
            if (redir) begin
                if (flush_eff == 2'd0) begin
                    state   <= S_RUN;
                    bub_cnt <= 2'd0;
                end else begin
                    state   <= S_BUBBLE;
                    bub_cnt <= flush_eff;
                end
            end else begin
                case (state)
                    S_IDLE:   state <= S_RUN;
                    S_RUN:    state <= S_RUN;
                    S_BUBBLE: begin
                        bub_cnt <= bub_cnt - 2'd1;
                        if (bub_cnt <= 2'd1) state <= S_RUN;
                    end
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.out_imem_ren    = ren_q;
    assign bus.out_imem_addr   = addr_q;
    assign bus.out_instr       = ent0.instr;
    assign bus.out_instr_pc    = ent0.pc;
    assign bus.out_instr_valid = (occ != 2'd0);
    assign bus.out_pc_reg      = pc;
endmodule

// File: tb/tb_switch_mcu_fetch_pc.sv
// Directed per-cycle vector table for the fetch unit, plus reset-mid-fetch and PC-wrap sequences.
module tb_switch_mcu_fetch_pc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    switch_mcu_fetch_pc_if ifc ();
    switch_mcu_fetch_pc_if iw ();

    switch_mcu_fetch_pc #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .in_clk(clk), .in_rst(rst), .bus(ifc.master)
    );
    switch_mcu_fetch_pc #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_w (
        .in_clk(clk), .in_rst(rst), .bus(iw.master)
    );

    assign ifc.in_imem_rdata = memf(ifc.out_imem_addr);
    assign iw.in_imem_rdata  = memf(iw.out_imem_addr);
    assign iw.in_pc_override = 1'b0;
    assign iw.in_pc_write    = 32'h0;
    assign iw.in_flush       = 2'd0;
    assign iw.in_dec_ready   = 1'b1;

    // fetch addresses seen on the wrap instance after the first reset release
    logic [31:0] w_addr [3];
    int          w_n = 0;
    initial for (int i = 0; i < 3; i++) w_addr[i] = 32'hDEAD_BEEF;
    always @(negedge clk) begin
        if (rst && iw.out_imem_ren && w_n < 3) begin
            w_addr[w_n] = iw.out_imem_addr;
            w_n++;
        end
    end

    typedef struct {
        logic        ovr;
        logic [31:0] wr;
        logic [1:0]  fl;
        logic        rdy;
        logic        ren;
        logic [31:0] addr;
        logic        val;
        logic [31:0] ipc;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t mk(logic o, logic [31:0] w, logic [1:0] f, logic r,
                                logic en, logic [31:0] a, logic v, logic [31:0] ip, logic [31:0] p);
        vec_t t;
        t.ovr = o; t.wr = w; t.fl = f; t.rdy = r;
        t.ren = en; t.addr = a; t.val = v; t.ipc = ip; t.pc = p;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    vec_t vecs [31];

    initial begin
        // expected outputs are sampled 1 ns after each rising edge
        vecs[0]  = mk(0, 32'h0,   2'd0, 0, 0, 32'h0,   0, 32'h0,   32'h0);
        vecs[1]  = mk(0, 32'h0,   2'd0, 0, 1, 32'h0,   0, 32'h0,   32'h4);
        vecs[2]  = mk(0, 32'h0,   2'd0, 0, 1, 32'h4,   1, 32'h0,   32'h8);
        vecs[3]  = mk(0, 32'h0,   2'd0, 0, 0, 32'h0,   1, 32'h0,   32'h8);
        vecs[4]  = mk(0, 32'h0,   2'd0, 0, 0, 32'h0,   1, 32'h0,   32'h8);
        vecs[5]  = mk(0, 32'h0,   2'd0, 0, 0, 32'h0,   1, 32'h0,   32'h8);
        vecs[6]  = mk(0, 32'h0,   2'd0, 0, 0, 32'h0,   1, 32'h0,   32'h8);
        vecs[7]  = mk(0, 32'h0,   2'd0, 1, 1, 32'h8,   1, 32'h4,   32'hC);
        vecs[8]  = mk(0, 32'h0,   2'd0, 1, 1, 32'hC,   1, 32'h8,   32'h10);
        vecs[9]  = mk(0, 32'h0,   2'd0, 1, 1, 32'h10,  1, 32'hC,   32'h14);
        vecs[10] = mk(0, 32'h0,   2'd0, 1, 1, 32'h14,  1, 32'h10,  32'h18);
        vecs[11] = mk(1, 32'h100, 2'd2, 1, 0, 32'h0,   0, 32'h0,   32'h100);
        vecs[12] = mk(1, 32'h100, 2'd2, 1, 0, 32'h0,   0, 32'h0,   32'h100);
        vecs[13] = mk(0, 32'h0,   2'd0, 1, 0, 32'h0,   0, 32'h0,   32'h100);
        vecs[14] = mk(0, 32'h0,   2'd0, 1, 1, 32'h100, 0, 32'h0,   32'h104);
        vecs[15] = mk(0, 32'h0,   2'd0, 1, 1, 32'h104, 1, 32'h100, 32'h108);
        vecs[16] = mk(1, 32'h200, 2'd0, 1, 0, 32'h0,   0, 32'h0,   32'h200);
        vecs[17] = mk(1, 32'h200, 2'd0, 1, 1, 32'h200, 0, 32'h0,   32'h204);
        vecs[18] = mk(1, 32'h200, 2'd0, 1, 1, 32'h204, 1, 32'h200, 32'h208);
        vecs[19] = mk(1, 32'h200, 2'd0, 1, 1, 32'h208, 1, 32'h204, 32'h20C);
        vecs[20] = mk(0, 32'h0,   2'd0, 1, 1, 32'h20C, 1, 32'h208, 32'h210);
        vecs[21] = mk(1, 32'h302, 2'd3, 1, 0, 32'h0,   0, 32'h0,   32'h302);
        vecs[22] = mk(0, 32'h0,   2'd0, 1, 0, 32'h0,   0, 32'h0,   32'h302);
        vecs[23] = mk(0, 32'h0,   2'd0, 1, 0, 32'h0,   0, 32'h0,   32'h302);
        vecs[24] = mk(0, 32'h0,   2'd0, 1, 1, 32'h302, 0, 32'h0,   32'h306);
        vecs[25] = mk(1, 32'h400, 2'd2, 1, 0, 32'h0,   0, 32'h0,   32'h400);
        vecs[26] = mk(0, 32'h0,   2'd0, 1, 0, 32'h0,   0, 32'h0,   32'h400);
        vecs[27] = mk(1, 32'h500, 2'd1, 1, 0, 32'h0,   0, 32'h0,   32'h500);
        vecs[28] = mk(0, 32'h0,   2'd0, 1, 0, 32'h0,   0, 32'h0,   32'h500);
        vecs[29] = mk(0, 32'h0,   2'd0, 1, 1, 32'h500, 0, 32'h0,   32'h504);
        vecs[30] = mk(0, 32'h0,   2'd0, 1, 1, 32'h504, 1, 32'h500, 32'h508);

        ifc.in_pc_override = 1'b0;
        ifc.in_pc_write    = 32'h0;
        ifc.in_flush       = 2'd0;
        ifc.in_dec_ready   = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ren",   {31'h0, ifc.out_imem_ren},    32'h0);
        chk("rst_addr",  ifc.out_imem_addr,            32'h0);
        chk("rst_valid", {31'h0, ifc.out_instr_valid}, 32'h0);
        chk("rst_instr", ifc.out_instr,                32'h0);
        chk("rst_ipc",   ifc.out_instr_pc,             32'h0);
        chk("rst_pc",    ifc.out_pc_reg,               32'h0);
        chk("rst_pc_w",  iw.out_pc_reg,                32'hFFFF_FFF8);
        rst = 1'b1;

        for (int i = 0; i < 31; i++) begin
            ifc.in_pc_override = vecs[i].ovr;
            ifc.in_pc_write    = vecs[i].wr;
            ifc.in_flush       = vecs[i].fl;
            ifc.in_dec_ready   = vecs[i].rdy;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ren", i),   {31'h0, ifc.out_imem_ren},    {31'h0, vecs[i].ren});
            chk($sformatf("v%0d_valid", i), {31'h0, ifc.out_instr_valid}, {31'h0, vecs[i].val});
            chk($sformatf("v%0d_pc", i),    ifc.out_pc_reg,               vecs[i].pc);
            if (vecs[i].ren)
                chk($sformatf("v%0d_addr", i), ifc.out_imem_addr, vecs[i].addr);
            if (vecs[i].val) begin
                chk($sformatf("v%0d_ipc", i),   ifc.out_instr_pc, vecs[i].ipc);
                chk($sformatf("v%0d_instr", i), ifc.out_instr,    memf(vecs[i].ipc));
            end
        end

        chk("wrap_a0", w_addr[0], 32'hFFFF_FFF8);
        chk("wrap_a1", w_addr[1], 32'hFFFF_FFFC);
        chk("wrap_a2", w_addr[2], 32'h0000_0000);

        // reset asserted while a fetch of 0x504 is outstanding
        ifc.in_pc_override = 1'b0;
        ifc.in_dec_ready   = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        chk("mid_rst_ren",   {31'h0, ifc.out_imem_ren},    32'h0);
        chk("mid_rst_addr",  ifc.out_imem_addr,            32'h0);
        chk("mid_rst_valid", {31'h0, ifc.out_instr_valid}, 32'h0);
        chk("mid_rst_pc",    ifc.out_pc_reg,               32'h0);
        chk("mid_rst_ipc",   ifc.out_instr_pc,             32'h0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_idle_ren", {31'h0, ifc.out_imem_ren}, 32'h0);
        @(posedge clk);
        #1;
        chk("rel_ren",  {31'h0, ifc.out_imem_ren}, 32'h1);
        chk("rel_addr", ifc.out_imem_addr,         32'h0);
        @(posedge clk);
        #1;
        chk("rel_valid", {31'h0, ifc.out_instr_valid}, 32'h1);
        chk("rel_ipc",   ifc.out_instr_pc,             32'h0);
        chk("rel_instr", ifc.out_instr,                memf(32'h0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/switch_mcu_fetch_pc.md
SWITCH_MCU_FETCH_PC -- requirements
Module: switch_mcu_fetch_pc

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter: FIFO_DEPTH, 2, instruction buffer entries (fixed at 2).
REQ-003 SHALL have port: in_clk  input  1  clock, all state on rising edge.
REQ-004 SHALL have port: in_rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: in_pc_override  input  1  level redirect request from jump EX unit.
REQ-006 SHALL have port: in_pc_write  input  32  redirect target.
REQ-007 SHALL have port: in_flush  input  2  bubble count accompanying redirect (0..2).
REQ-008 SHALL have port: out_imem_ren  output  1  registered instruction memory read enable.
REQ-009 SHALL have port: out_imem_addr  output  32  registered fetch address.
REQ-010 SHALL have port: in_imem_rdata  input  32  fetched word, valid the cycle after out_imem_ren=1.
REQ-011 SHALL have port: out_instr  output  32  instruction to decoder (FIFO head).
REQ-012 SHALL have port: out_instr_pc  output  32  address of out_instr.
REQ-013 SHALL have port: out_instr_valid  output  1  out_instr valid.
REQ-014 SHALL have port: in_dec_ready  input  1  decoder accepts head when valid and ready.
REQ-015 SHALL have port: out_pc_reg  output  32  PC register (next fetch address), feeds EX.

Function
REQ-016 SHALL implement states S_IDLE, S_RUN, S_BUBBLE; S_IDLE lasts exactly one cycle after reset release, then S_RUN.
REQ-017 SHALL, in S_RUN, issue a fetch (out_imem_ren=1, out_imem_addr=pc, pc<=pc+4) when FIFO occupancy plus in-flight fetches, counted after this cycle's pop, is below 2.
REQ-018 SHALL push in_imem_rdata and its address into the FIFO in the cycle after an issue, unless that fetch was cancelled.
REQ-019 SHALL pop the head on out_instr_valid && in_dec_ready; simultaneous push and pop SHALL keep occupancy unchanged.
REQ-020 SHALL drive out_instr_valid=1 iff occupancy>0; out_instr/out_instr_pc SHALL hold stable while valid and not ready.
REQ-021 SHALL detect redirect as a rising edge of in_pc_override (registered previous value); a held level SHALL not retrigger.
REQ-022 SHALL, on redirect edge: pc<=in_pc_write; clear FIFO; cancel in-flight fetch (response discarded); suppress issue that cycle.
REQ-023 SHALL, on redirect with in_flush=0, return to S_RUN next cycle; otherwise enter S_BUBBLE with bubble counter=in_flush.
REQ-024 SHALL, in S_BUBBLE, issue no fetch and decrement counter each cycle; exit to S_RUN when counter reaches 1 -> 0.
REQ-025 SHALL treat in_flush=3 as 2.
REQ-026 SHALL give redirect priority over pop, push and issue in the same cycle.
REQ-027 SHALL accept a new redirect edge in S_BUBBLE, reloading pc and counter.
REQ-028 SHALL wrap pc modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-029 SHALL not alter the low two bits of in_pc_write (alignment is EX's responsibility).

Reset
REQ-030 SHALL, while in_rst=0: pc=RESET_PC, state=S_IDLE, FIFO empty, counter=0, edge register=0, out_imem_ren=0, out_imem_addr=0, out_instr=0, out_instr_pc=0, out_instr_valid=0, out_pc_reg=RESET_PC.
REQ-031 SHALL, on reset assertion mid-fetch, discard in-flight data; first fetch after release SHALL use RESET_PC.

Verification
REQ-032 SHALL be verified: reset release, in_dec_ready=1 -> fetches at 0,4,8,... one per cycle, first out_instr_valid 2 cycles after S_IDLE exit.
REQ-033 SHALL be verified: in_dec_ready=0 for 5 cycles -> FIFO holds 0x0 and 0x4, no third issue, out_instr stays 0x0 entry.
REQ-034 SHALL be verified: redirect to 0x100, in_flush=2 -> FIFO cleared next cycle, 2 cycles without ren, next fetch addr 0x100.
REQ-035 SHALL be verified: redirect in_flush=0 while fetch in flight -> stale word not pushed, next fetch addr equals target.
REQ-036 SHALL be verified: in_pc_override held high 4 cycles -> exactly one redirect.
REQ-037 SHALL be verified: RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
